// File: rtl/res_arb_pkg.sv
// ============================================================================
//  Module      : res_arb_pkg
//  Description : Shared types and helpers for resource_arbiter.
//                - state_e : arbiter FSM states (IDLE, OWN)
//                - tag_t   : {valid, id} tag carried alongside each issued beat
//                - id_w()  : width of a client ID for n clients
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package res_arb_pkg;

    // Wide enough for the largest supported client count (16).
    localparam int MAX_ID_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/res_arb_tag_pipe.sv
// ============================================================================
//  Module      : res_arb_tag_pipe
//  Description : RES_LAT-deep shift register of beat tags. Lines the owner ID
//                up with the resource result. RES_LAT=0 is a pure bypass.
//  Ports       : clk    in  clock, rising edge
//                reset  in  asynchronous active-high reset
//                flush  in  synchronous clear of every stage
//                tag_i  in  tag of the beat issued this cycle
//                tag_o  out tag of the beat whose result appears this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module res_arb_tag_pipe
    import res_arb_pkg::*;
#(
    parameter int RES_LAT = 0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic flush,
    input  wire tag_t tag_i,
    output tag_t      tag_o
);

    if (RES_LAT == 0) begin : g_bypass
        // Combinational resource: the tag is consumed in the cycle it is made.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, reset, flush};
        assign tag_o       = tag_i;
    end else begin : g_pipe
        tag_t stage_q [RES_LAT];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < RES_LAT; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (flush) begin
                for (int i = 0; i < RES_LAT; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= tag_i;
                for (int i = 1; i < RES_LAT; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign tag_o = stage_q[RES_LAT-1];
    end

endmodule

`default_nettype wire

// File: rtl/resource_arbiter.sv
// ============================================================================
//  Module      : resource_arbiter
//  Description : Shares one resource port among NUM_REQ clients. Round-robin
//                arbitration with a per-owner hold limit; each issued beat is
//                tagged with its owner and the result is routed back through
//                a RES_LAT-deep tag pipe.
//  Ports       : clk             in  clock, rising edge
//                reset           in  asynchronous active-high reset
//                flush           in  synchronous abort of grant/in-flight beats
//                arbiter_req     in  per-client request (level)
//                req_data        in  per-client data, slice i = client i
//                arbiter_grant   out registered one-hot (or zero) grant
//                resource_input  out muxed owner data, zero when idle
//                res_valid       out resource_input carries a live beat
//                resource_output in  resource result
//                rsp_valid       out one-hot owner of the current result
//                rsp_data        out resource_output broadcast
//                starve_flag     out per-client starvation flag (optional)
//  Options     : `define RESOURCE_ARBITER_STARVE_EN adds starve_flag and the
//                STARVE_LIM parameter with per-client wait counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resource_arbiter
    import res_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8,
    parameter int RES_LAT  = 0
`ifdef RESOURCE_ARBITER_STARVE_EN
    ,
    parameter int STARVE_LIM = 32
`endif
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      flush,
    input  wire logic [NUM_REQ-1:0]        arbiter_req,
    input  wire logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic      [NUM_REQ-1:0]        arbiter_grant,
    output logic      [DATA_W-1:0]         resource_input,
    output logic                           res_valid,
    input  wire logic [DATA_W-1:0]         resource_output,
    output logic      [NUM_REQ-1:0]        rsp_valid,
    output logic      [DATA_W-1:0]         rsp_data
`ifdef RESOURCE_ARBITER_STARVE_EN
    ,
    output logic      [NUM_REQ-1:0]        starve_flag
`endif
);

    localparam int ID_W   = id_w(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("resource_arbiter: NUM_REQ must be in 2..16");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("resource_arbiter: MAX_HOLD must be >= 1");
    end
    if (RES_LAT < 0) begin : g_bad_res_lat
        $error("resource_arbiter: RES_LAT must be >= 0");
    end

    // ------------------------------------------------------------------
    // State. While in OWN, rr_ptr_q is also the current owner's ID.
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [HOLD_W-1:0]  hold_cnt_q;

    logic               any_req;
    logic               others_req;
    logic               issue;
    logic               hold_at_limit;
    logic [ID_W-1:0]    winner;
    logic [NUM_REQ-1:0] win_onehot;
    logic [DATA_W-1:0]  mux_data;

    assign any_req       = |arbiter_req;
    assign others_req    = |(arbiter_req & ~grant_q);
    assign issue         = |(grant_q & arbiter_req);
    assign hold_at_limit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

    // Round-robin search starting at rr_ptr_q+1. The lowest requester
    // above the pointer wins; failing that, the search wraps and the
    // lowest requester overall wins. The current owner sits at the
    // pointer, so it is only picked when nobody else is asking.
    always_comb begin
        logic            hi_found;
        logic [ID_W-1:0] hi_idx;
        logic [ID_W-1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (arbiter_req[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
                lo_idx = ID_W'(i);
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (winner == ID_W'(i));
        end
    end

    // AND-OR mux keyed by the one-hot grant.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                mux_data = mux_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
        end else if (flush) begin
            // Pointer is kept so fairness survives the abort.
            state_q    <= IDLE;
            grant_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= OWN;
                        grant_q    <= win_onehot;
                        rr_ptr_q   <= winner;
                        hold_cnt_q <= '0;
                    end
                end
                OWN: begin
                    if (!issue) begin
                        // Owner dropped its request: hand over without a
                        // bubble if anyone else waits, otherwise go idle.
                        hold_cnt_q <= '0;
                        if (any_req) begin
                            grant_q  <= win_onehot;
                            rr_ptr_q <= winner;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (hold_at_limit) begin
                        // Last beat of this tenure. With no competitor the
                        // owner simply starts a fresh tenure.
                        hold_cnt_q <= '0;
                        if (others_req) begin
                            grant_q  <= win_onehot;
                            rr_ptr_q <= winner;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign arbiter_grant  = grant_q;
    assign res_valid      = issue;
    assign resource_input = issue ? mux_data : '0;

    // ------------------------------------------------------------------
    // Response routing. A beat issued in a flush cycle never enters
    // the tag pipe, so its result is not routed to anyone.
    // ------------------------------------------------------------------
    tag_t tag_in;
    tag_t tag_out;

    assign tag_in.valid = issue & ~flush;
    assign tag_in.id    = MAX_ID_W'(rr_ptr_q);

    res_arb_tag_pipe #(
        .RES_LAT (RES_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_out.valid && (tag_out.id == MAX_ID_W'(i));
        end
    end

    assign rsp_data = resource_output;

    // ------------------------------------------------------------------
    // Optional starvation monitor. Purely observational.
    // ------------------------------------------------------------------
`ifdef RESOURCE_ARBITER_STARVE_EN
    localparam int SW = $clog2(STARVE_LIM + 1);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
        logic [SW-1:0] wait_q;
        logic [SW-1:0] wait_d;
        logic          flag_q;

        always_comb begin
            wait_d = wait_q;
            if (flush || grant_q[gi]) begin
                wait_d = '0;
            end else if (arbiter_req[gi] && (wait_q != SW'(STARVE_LIM))) begin
                wait_d = wait_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wait_q <= '0;
                flag_q <= 1'b0;
            end else begin
                wait_q <= wait_d;
                flag_q <= (wait_d == SW'(STARVE_LIM));
            end
        end

        assign starve_flag[gi] = flag_q;
    end
`endif

endmodule

`default_nettype wire
